// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational reads, two prioritised writes,
// optional write-to-read bypass and hardwired zero entry, swept clear on reset.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 6,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we0,
   input  logic [ADDR_W-1:0] wa0,
   input  logic [DATA_W-1:0] wd0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] wa1,
   input  logic [DATA_W-1:0] wd1,
   input  logic [ADDR_W-1:0] ra0,
   output logic [DATA_W-1:0] rd0,
   input  logic [ADDR_W-1:0] ra1,
   output logic [DATA_W-1:0] rd1,
   output logic              ready
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam bit ZR    = (ZERO_REG != 0);
   localparam bit BP    = (BYPASS != 0);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   ptr, ptr_nx;
   logic                ready_nx;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                wr0, wr1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR;
         ptr   <= '0;
         ready <= 1'b0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         ready <= ready_nx;
      end
   end

   // ptr stops at the last entry once the sweep is done
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      ready_nx = ready;
      case (state)
         CLEAR: begin
            if (ptr == '1) begin
               state_nx = RUN;
               ready_nx = 1'b1;
            end else begin
               ptr_nx = ptr + 1'b1;
            end
         end
         RUN: ;
         default: state_nx = CLEAR;
      endcase
   end

   // Dropped zero-register writes neither commit nor bypass
   assign wr0 = (state == RUN) && we0 && !(ZR && wa0 == '0);
   assign wr1 = (state == RUN) && we1 && !(ZR && wa1 == '0);

   // Port 1 is written last so it wins on an address collision
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[ptr] <= '0;
         end else begin
            if (wr0) mem[wa0] <= wd0;
            if (wr1) mem[wa1] <= wd1;
         end
      end
   end

   function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] ra);
      logic [DATA_W-1:0] r;
      if (!ready)
         r = '0;
      else if (ZR && ra == '0)
         r = '0;
      else if (BP && wr1 && wa1 == ra)
         r = wd1;
      else if (BP && wr0 && wa0 == ra)
         r = wd0;
      else
         r = mem[ra];
      return r;
   endfunction

   always_comb begin
      rd0 = rd_sel(ra0);
      rd1 = rd_sel(ra1);
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-based model
// covering default, no-bypass/zero-register and narrow configurations.
module tb_regfile_mp;

   logic        clk;
   logic        reset;
   logic        we0, we1;
   logic [5:0]  wa0, wa1, ra0, ra1;
   logic [31:0] wd0, wd1;
   logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
   logic        a_ready, b_ready;

   logic        s_reset;
   logic        s_we0, s_we1;
   logic [2:0]  s_wa0, s_wa1, s_ra0, s_ra1;
   logic [15:0] s_wd0, s_wd1, s_rd0, s_rd1;
   logic        s_ready;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m0 [64];
   logic [31:0] m1 [64];
   bit          mrdy;
   int          mcnt;

   regfile_mp u_a (
      .clk(clk), .reset(reset),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra0(ra0), .rd0(a_rd0), .ra1(ra1), .rd1(a_rd1),
      .ready(a_ready)
   );

   regfile_mp #(.ZERO_REG(1), .BYPASS(0)) u_b (
      .clk(clk), .reset(reset),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra0(ra0), .rd0(b_rd0), .ra1(ra1), .rd1(b_rd1),
      .ready(b_ready)
   );

   regfile_mp #(.DATA_W(16), .ADDR_W(3)) u_s (
      .clk(clk), .reset(s_reset),
      .we0(s_we0), .wa0(s_wa0), .wd0(s_wd0),
      .we1(s_we1), .wa1(s_wa1), .wd1(s_wd1),
      .ra0(s_ra0), .rd0(s_rd0), .ra1(s_ra1), .rd1(s_rd1),
      .ready(s_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // k=0: bypass, no zero reg; k=1: zero reg, no bypass
   function automatic logic [31:0] exp_rd(input int k, input logic [5:0] ra);
      if (!mrdy) return 32'h0;
      if (k == 1 && ra == 6'd0) return 32'h0;
      if (k == 0 && we1 && wa1 == ra) return wd1;
      if (k == 0 && we0 && wa0 == ra) return wd0;
      return (k == 0) ? m0[ra] : m1[ra];
   endfunction

   task automatic chk_all(input string tag);
      chk({tag, "_rdyA"}, {31'b0, a_ready}, {31'b0, mrdy});
      chk({tag, "_rdyB"}, {31'b0, b_ready}, {31'b0, mrdy});
      chk({tag, "_A0"}, a_rd0, exp_rd(0, ra0));
      chk({tag, "_A1"}, a_rd1, exp_rd(0, ra1));
      chk({tag, "_B0"}, b_rd0, exp_rd(1, ra0));
      chk({tag, "_B1"}, b_rd1, exp_rd(1, ra1));
   endtask

   // Model: array is all-zero once DEPTH clear edges pass; writes in RUN only
   task automatic model_edge();
      if (reset) begin
         mrdy = 1'b0;
         mcnt = 0;
      end else if (!mrdy) begin
         mcnt++;
         if (mcnt == 64) begin
            mrdy = 1'b1;
            for (int i = 0; i < 64; i++) begin
               m0[i] = 32'h0;
               m1[i] = 32'h0;
            end
         end
      end else begin
         if (we0) begin
            m0[wa0] = wd0;
            if (wa0 != 6'd0) m1[wa0] = wd0;
         end
         if (we1) begin
            m0[wa1] = wd1;
            if (wa1 != 6'd0) m1[wa1] = wd1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < 64; i++) begin
         ra0 = 6'(i);
         ra1 = 6'(63 - i);
         #1;
         chk_all(tag);
      end
   endtask

   initial begin
      int cnt;
      mrdy = 0; mcnt = 0;
      idle();
      ra0 = 0; ra1 = 0; reset = 1;
      s_reset = 1; s_we0 = 0; s_we1 = 0; s_wa0 = 0; s_wa1 = 0;
      s_wd0 = 0; s_wd1 = 0; s_ra0 = 0; s_ra1 = 0;

      // reset with we0 active; sweep must ignore writes
      we0 = 1; wa0 = 6'd3; wd0 = 32'h1234_5678;
      tick();
      #1;
      chk_all("reset");
      reset = 0;
      cnt = 0;
      for (int e = 1; e <= 64; e++) begin
         wa0 = 6'($urandom);
         wd0 = $urandom;
         ra0 = wa0;
         #1;
         chk_all("sweep");
         tick();
         cnt++;
         if (a_ready) break;
      end
      chk("rdy_edge", 32'(cnt), 32'd64);
      chk("rdy_after", {31'b0, a_ready}, 32'd1);
      idle();
      read_all("cleared");

      // same-cycle write and read of entry 5
      we0 = 1; wa0 = 6'd5; wd0 = 32'hDEAD_BEEF; ra0 = 6'd5; ra1 = 6'd5;
      #1;
      chk("byp_5", a_rd0, 32'hDEAD_BEEF);
      chk("nobyp_5", b_rd0, 32'h0);
      tick();
      idle();
      #1;
      chk("post_5A", a_rd0, 32'hDEAD_BEEF);
      chk("post_5B", b_rd0, 32'hDEAD_BEEF);

      // port collision on entry 9
      we0 = 1; we1 = 1; wa0 = 6'd9; wa1 = 6'd9;
      wd0 = 32'h1111_1111; wd1 = 32'h2222_2222; ra0 = 6'd9; ra1 = 6'd9;
      #1;
      chk("coll_byp", a_rd0, 32'h2222_2222);
      chk_all("coll");
      tick();
      idle();
      #1;
      chk("coll_A", a_rd1, 32'h2222_2222);
      chk("coll_B", b_rd1, 32'h2222_2222);

      // zero register writes on both ports
      we0 = 1; we1 = 1; wa0 = 0; wa1 = 0;
      wd0 = 32'hFFFF_FFFF; wd1 = 32'hFFFF_FFFF; ra0 = 0; ra1 = 0;
      #1;
      chk("zr_now0", b_rd0, 32'h0);
      chk("zr_now1", b_rd1, 32'h0);
      tick();
      idle();
      #1;
      chk("zr_aft0", b_rd0, 32'h0);
      chk("zr_aft1", b_rd1, 32'h0);
      chk_all("zr");

      // randomised traffic with occasional reset
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         we0 = 1'($urandom);
         we1 = 1'($urandom);
         wa0 = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
         wa1 = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
         wd0 = $urandom;
         wd1 = $urandom;
         case ($urandom_range(0, 2))
            0: ra0 = wa0;
            1: ra0 = wa1;
            default: ra0 = 6'($urandom);
         endcase
         ra1 = ($urandom_range(0, 1) == 1) ? wa1 : 6'($urandom_range(0, 3));
         #1;
         chk_all("rand");
         tick();
      end
      reset = 0;
      idle();
      cnt = 0;
      while (!mrdy && cnt < 100) begin
         tick();
         cnt++;
      end

      // fill with index, then reset mid-sweep
      for (int i = 0; i < 64; i++) begin
         we0 = 1; wa0 = 6'(i); wd0 = 32'(i);
         tick();
      end
      idle();
      read_all("fill");
      reset = 1;
      tick();
      reset = 0;
      for (int i = 0; i < 20; i++) tick();
      reset = 1;
      tick();
      reset = 0;
      cnt = 0;
      while (!a_ready && cnt < 200) begin
         #1;
         chk_all("resweep");
         tick();
         cnt++;
      end
      chk("resweep_edges", 32'(cnt), 32'd64);
      read_all("recleared");

      // narrow configuration
      s_reset = 1;
      tick();
      s_reset = 0;
      cnt = 0;
      while (!s_ready && cnt < 50) begin
         tick();
         cnt++;
      end
      chk("s_edges", 32'(cnt), 32'd8);
      s_we0 = 1; s_wa0 = 3'd7; s_wd0 = 16'hABCD; s_ra0 = 3'd7; s_ra1 = 3'd6;
      #1;
      chk("s_byp", {16'h0, s_rd0}, 32'h0000_ABCD);
      tick();
      s_we0 = 0;
      #1;
      chk("s_rd7", {16'h0, s_rd0}, 32'h0000_ABCD);
      chk("s_rd6", {16'h0, s_rd1}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
